// File: rtl/regfile_ww_param.sv
`default_nettype none
// ============================================================================
// Module      : regfile_ww_param
// Description : Parametrised wide-word register file with byte-enable write,
//               registered multi-port reads, write bypass and a clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_ww_param #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr_req,
    output logic                       busy,
    input  logic                       wren,
    input  logic [ADDR_W-1:0]          wraddr,
    input  logic [DATA_W-1:0]          wrdata,
    input  logic [BE_W-1:0]            wrbyteen,
    input  logic [NUM_RD-1:0]          rden,
    input  logic [NUM_RD*ADDR_W-1:0]   rdaddr,
    output logic [NUM_RD*DATA_W-1:0]   rddata,
    output logic [NUM_RD-1:0]          rdvalid
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_ptr;
    logic [ADDR_W-1:0]   w_clr_ptr_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   w_old;
    logic [DATA_W-1:0]   w_merged;
    logic                w_ready;
    logic                w_wr_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        case (r_state)
            ST_CLEAR: begin
                w_clr_ptr_nxt = r_clr_ptr + 1'b1;
                if (r_clr_ptr == c_LAST_ADDR) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (clr_req) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_ptr_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = ST_CLEAR;
                w_clr_ptr_nxt = '0;
            end
        endcase
    end

    assign busy    = (r_state == ST_CLEAR);
    assign w_ready = (r_state == ST_READY);
    assign w_wr_en = w_ready && wren && !reset;
    assign w_old   = r_mem[wraddr];

    // Post-write word: shared by the array update and the read bypass.
    for (genvar i = 0; i < BE_W; i++) begin : g_byte
        assign w_merged[8*i +: 8] = wrbyteen[i] ? wrdata[8*i +: 8] : w_old[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (!reset && (r_state == ST_CLEAR)) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_wr_en) begin
            r_mem[wraddr] <= w_merged;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_hit;
        logic [DATA_W-1:0] r_data;
        logic              r_valid;

        assign w_addr = rdaddr[p*ADDR_W +: ADDR_W];
        assign w_hit  = wren && (w_addr == wraddr);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else if (w_ready && rden[p]) begin
                r_data  <= w_hit ? w_merged : r_mem[w_addr];
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end

        assign rddata[p*DATA_W +: DATA_W] = r_data;
        assign rdvalid[p]                 = r_valid;
    end

endmodule
`default_nettype wire
